// File: rtl/wb_opb_master_attach.sv
// Wishbone slave to OPB master bridge: each WB cycle becomes one OPB transfer,
// with arbitration, retry and grant-timeout handling and one-cycle ack/err response.
`timescale 1ns/1ps

module wb_opb_master_attach #(
    parameter logic [31:0] C_BASEADDR      = 32'h0,
    parameter int unsigned C_MAX_RETRY     = 8,
    parameter int unsigned C_GRANT_TIMEOUT = 256
) (
    input  logic        OPB_Clk,
    input  logic        OPB_Rst_n,
    // Wishbone slave port
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    // OPB master outputs
    output logic        M_request,
    output logic        M_select,
    output logic        M_RNW,
    output logic [3:0]  M_BE,
    output logic [31:0] M_ABus,
    output logic [31:0] M_DBus,
    output logic        M_seqAddr,
    output logic        M_busLock,
    // OPB inputs
    input  logic        OPB_MGrant,
    input  logic [31:0] OPB_DBus,
    input  logic        OPB_xferAck,
    input  logic        OPB_errAck,
    input  logic        OPB_retry,
    input  logic        OPB_timeout
);

    localparam int unsigned GCNT_W = 16;
    localparam int unsigned RCNT_W = 8;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_XFER  = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ABORT = 3'd4;

    typedef struct packed {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
    } wb_req_t;

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    wb_req_t           r_req;
    logic [GCNT_W-1:0] r_gcnt;
    logic [RCNT_W-1:0] r_rcnt;
    logic              r_abandon;

    logic              w_latch;
    logic              w_gcnt_clr;
    logic              w_gcnt_inc;
    logic              w_rcnt_inc;
    logic              w_abandon_set;
    logic              w_err_nxt;
    logic              w_capture;
    logic              w_fin;
    logic              w_gone;
    logic [RCNT_W-1:0] w_rcnt_plus;
    logic              w_xfer_nxt;
    logic              w_done_nxt;
    logic [31:0]       w_abus;

    assign w_rcnt_plus = r_rcnt + RCNT_W'(1);
    assign w_gone      = r_abandon | ~wb_cyc_i;
    assign w_xfer_nxt  = (w_state_nxt == S_XFER);
    assign w_done_nxt  = (w_state_nxt == S_DONE);
    assign w_abus      = r_req.adr + C_BASEADDR;

    // State register
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath control
    always_comb begin
        w_state_nxt   = r_state;
        w_latch       = 1'b0;
        w_gcnt_clr    = 1'b0;
        w_gcnt_inc    = 1'b0;
        w_rcnt_inc    = 1'b0;
        w_abandon_set = 1'b0;
        w_err_nxt     = 1'b0;
        w_capture     = 1'b0;
        w_fin         = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    w_latch     = 1'b1;
                    w_state_nxt = S_REQ;
                end
            end

            S_REQ: begin
                w_gcnt_inc = 1'b1;
                if (!wb_cyc_i) begin
                    w_state_nxt = S_IDLE;
                end else if (OPB_MGrant) begin
                    w_state_nxt = S_XFER;
                end else if (r_gcnt == GCNT_W'(C_GRANT_TIMEOUT - 1)) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end

            S_XFER: begin
                w_abandon_set = ~wb_cyc_i;
                if (OPB_errAck || OPB_timeout) begin
                    w_fin     = 1'b1;
                    w_err_nxt = 1'b1;
                end else if (OPB_retry) begin
                    w_rcnt_inc = 1'b1;
                    if (w_rcnt_plus == RCNT_W'(C_MAX_RETRY)) begin
                        w_fin     = 1'b1;
                        w_err_nxt = 1'b1;
                    end else if (w_gone) begin
                        // Master has left: do not re-arbitrate on its behalf
                        w_state_nxt = S_ABORT;
                    end else begin
                        w_gcnt_clr  = 1'b1;
                        w_state_nxt = S_REQ;
                    end
                end else if (OPB_xferAck) begin
                    w_fin     = 1'b1;
                    w_capture = ~r_req.we;
                end

                if (w_fin) begin
                    w_state_nxt = w_gone ? S_ABORT : S_DONE;
                end
            end

            S_DONE:  w_state_nxt = S_IDLE;
            S_ABORT: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Latched request, counters and abandon flag
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            r_req     <= '0;
            r_gcnt    <= '0;
            r_rcnt    <= '0;
            r_abandon <= 1'b0;
        end else begin
            if (w_latch) begin
                r_req <= '{we: wb_we_i, sel: wb_sel_i, adr: wb_adr_i, dat: wb_dat_i};
            end

            if (w_latch || w_gcnt_clr) begin
                r_gcnt <= '0;
            end else if (w_gcnt_inc) begin
                r_gcnt <= r_gcnt + GCNT_W'(1);
            end

            if (w_latch) begin
                r_rcnt <= '0;
            end else if (w_rcnt_inc) begin
                r_rcnt <= w_rcnt_plus;
            end

            if (w_latch) begin
                r_abandon <= 1'b0;
            end else if (w_abandon_set) begin
                r_abandon <= 1'b1;
            end
        end
    end

    // Outputs are decoded from the next state so they line up with the state register
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            M_request <= 1'b0;
            M_select  <= 1'b0;
            M_RNW     <= 1'b0;
            M_BE      <= '0;
            M_ABus    <= '0;
            M_DBus    <= '0;
            wb_ack_o  <= 1'b0;
            wb_err_o  <= 1'b0;
            wb_dat_o  <= '0;
        end else begin
            M_request <= (w_state_nxt == S_REQ);
            M_select  <= w_xfer_nxt;
            M_RNW     <= w_xfer_nxt & ~r_req.we;
            M_BE      <= w_xfer_nxt ? r_req.sel : 4'h0;
            M_ABus    <= w_xfer_nxt ? w_abus : 32'h0;
            M_DBus    <= (w_xfer_nxt && r_req.we) ? r_req.dat : 32'h0;
            wb_ack_o  <= w_done_nxt & ~w_err_nxt;
            wb_err_o  <= w_done_nxt & w_err_nxt;
            // Read register: only holds data for the single DONE cycle of a good read
            wb_dat_o  <= (w_done_nxt && w_capture) ? OPB_DBus : 32'h0;
        end
    end

    assign M_seqAddr = 1'b0;
    assign M_busLock = 1'b0;

endmodule

// File: doc/wb_opb_master_attach.md
WB_OPB_MASTER_ATTACH -- requirements
Module: wb_opb_master_attach

Interface
REQ-001 The block SHALL have parameter C_BASEADDR, default 32'h0, the offset added to every WB address to form the OPB address.
REQ-002 The block SHALL have parameter C_MAX_RETRY, default 8, the OPB retries allowed per transfer before an error is returned (range 1-255).
REQ-003 The block SHALL have parameter C_GRANT_TIMEOUT, default 256, the cycles to wait for OPB_MGrant before an error is returned (range 1-65535).
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset; the ports are OPB_Clk (in, 1, clock) and OPB_Rst_n (in, 1, reset).
REQ-005 The WB slave port SHALL be: wb_cyc_i in 1; wb_stb_i in 1; wb_we_i in 1; wb_sel_i in 4; wb_adr_i in 32; wb_dat_i in 32; wb_dat_o out 32; wb_ack_o out 1; wb_err_o out 1.
REQ-006 The OPB master outputs SHALL be: M_request out 1; M_select out 1; M_RNW out 1; M_BE out 4; M_ABus out 32; M_DBus out 32; M_seqAddr out 1; M_busLock out 1.
REQ-007 The OPB inputs SHALL be: OPB_MGrant in 1; OPB_DBus in 32; OPB_xferAck in 1; OPB_errAck in 1; OPB_retry in 1; OPB_timeout in 1.

Function
REQ-008 The FSM SHALL have exactly five states: IDLE, REQ, XFER, DONE and ABORT.
REQ-009 In IDLE, wb_cyc_i&&wb_stb_i SHALL do the following on that edge: latch adr, dat, sel and we into registers; clear the retry and grant counters; move to REQ.
REQ-010 In REQ, M_request SHALL be 1 and the grant counter SHALL increment every cycle.
REQ-011 In REQ, when OPB_MGrant=1, the FSM SHALL move to XFER on the next edge.
REQ-012 In REQ, when the grant counter reaches C_GRANT_TIMEOUT-1 without a grant, the FSM SHALL move to DONE with the error flag set.
REQ-013 In REQ, when wb_cyc_i=0 (master abandons the cycle), the FSM SHALL move to IDLE with no WB response.
REQ-014 In XFER, M_select SHALL be 1 and M_request SHALL be 0.
REQ-015 In XFER, M_ABus SHALL equal latched adr + C_BASEADDR (mod 2^32), M_BE SHALL equal latched sel, and M_RNW SHALL equal ~latched we.
REQ-016 In XFER, M_DBus SHALL equal latched dat for writes and 0 for reads.
REQ-017 In every state other than XFER, M_select, M_ABus, M_BE and M_DBus SHALL be 0 and M_RNW SHALL be 0.
REQ-018 M_seqAddr and M_busLock SHALL be tied to 0.
REQ-019 XFER responses SHALL be resolved with priority OPB_errAck > OPB_timeout > OPB_retry > OPB_xferAck.
REQ-020 In XFER, OPB_errAck=1 or OPB_timeout=1 SHALL move the FSM to DONE with the error flag set.
REQ-021 In XFER, OPB_retry=1 SHALL increment the retry counter and move the FSM to REQ; when the incremented count equals C_MAX_RETRY, the FSM SHALL instead move to DONE with the error flag set.
REQ-022 In XFER, OPB_xferAck=1 SHALL move the FSM to DONE with the error flag clear, and on reads SHALL capture OPB_DBus into the read register on the same edge.
REQ-023 In XFER, when no response input is asserted, the FSM SHALL stay in XFER; the arbiter's OPB_timeout bounds this wait.
REQ-024 In DONE, exactly one of wb_ack_o and wb_err_o SHALL be 1 for one cycle, and the FSM SHALL return to IDLE on the next edge.
REQ-025 wb_ack_o and wb_err_o SHALL never both be 1, and neither SHALL be asserted outside DONE.
REQ-026 wb_dat_o SHALL present the read register during DONE of a successful read and 0 otherwise.
REQ-027 When wb_cyc_i falls while the FSM is in XFER, the OPB transfer SHALL still complete, and the FSM SHALL then go to ABORT and from there to IDLE, suppressing wb_ack_o/wb_err_o.
REQ-028 Minimum latency for a granted, immediately acknowledged access SHALL be: stb sampled (edge 0), REQ (grant seen at edge 1), XFER (xferAck at edge 2), DONE (ack visible cycle 3), IDLE at edge 3.
REQ-029 A new WB request SHALL be accepted no earlier than the IDLE cycle that follows DONE; there is no pipelining.

Reset
REQ-030 While OPB_Rst_n=0, the following SHALL hold immediately, independent of the clock: FSM in IDLE; all OPB master outputs 0; wb_ack_o=0; wb_err_o=0; wb_dat_o=0; all latched registers and counters 0.
REQ-031 Reset asserted mid-transfer SHALL drop M_select and M_request at once and produce no WB response.
REQ-032 After release, the first edge with OPB_Rst_n=1 SHALL be able to accept a request.

Verification
REQ-033 Write scenario: adr=0x10, dat=0xA5A5_0001, sel=4'hF, C_BASEADDR=0x8000_0000, grant and xferAck each given one cycle after the request -> M_ABus=0x8000_0010, M_DBus=0xA5A5_0001, M_RNW=0; wb_ack_o=1 for one cycle, 3 cycles after the request.
REQ-034 Read scenario: OPB_DBus=0xDEAD_BEEF with xferAck -> wb_dat_o=0xDEAD_BEEF while wb_ack_o=1; M_DBus=0 throughout.
REQ-035 Retry scenario: OPB_retry asserted on 2 consecutive attempts and xferAck on the 3rd -> M_request reasserts twice and a single wb_ack_o is returned; with C_MAX_RETRY=2 the same stimulus -> wb_err_o.
REQ-036 Grant timeout scenario: C_GRANT_TIMEOUT=4 and OPB_MGrant held 0 -> wb_err_o after 4 REQ cycles and M_select never asserted.
REQ-037 Simultaneous-response scenario: errAck and xferAck asserted in the same cycle -> wb_err_o only.
REQ-038 Abort scenario: wb_cyc_i dropped during REQ -> IDLE with no response; reset pulsed during XFER -> all outputs 0 immediately.
